// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Stall/flush scheduler and interrupt-entry sequencer for the
//             five-stage pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_W        = 4,
    parameter int MEM_WAIT     = 1,
    parameter int INT_PUSH_CYC = 2,
    parameter int INT_VEC_CYC  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src1_used,
    input  logic             id_src2_used,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_wide,
    input  logic             int_req,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             stall_mem,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [1:0]       pc_sel,
    output logic             int_ack,
    output logic [2:0]       state_o
);

    // Debug encoding visible on state_o.
    localparam logic [2:0] c_ST_RUN     = 3'd0;
    localparam logic [2:0] c_ST_MEMWAIT = 3'd1;
    localparam logic [2:0] c_ST_DRAIN   = 3'd2;
    localparam logic [2:0] c_ST_PUSH    = 3'd3;
    localparam logic [2:0] c_ST_VEC     = 3'd4;
    localparam logic [2:0] c_ST_ACK     = 3'd5;

    localparam logic [3:0] c_MEM_CNT   = 4'(MEM_WAIT - 1);
    localparam logic [3:0] c_DRAIN_CNT = 4'd2;
    localparam logic [3:0] c_PUSH_CNT  = 4'(INT_PUSH_CYC - 1);
    localparam logic [3:0] c_VEC_CNT   = 4'(INT_VEC_CYC - 1);

    logic [2:0] r_state;
    logic [3:0] r_cnt;
    logic       r_int_pend;

    logic [2:0] w_nxt_state;
    logic [3:0] w_nxt_cnt;
    logic       w_load_use;
    logic       w_cnt_zero;
    logic       w_stall_if, w_stall_id, w_bubble_ex, w_stall_mem;
    logic       w_flush_ifid, w_flush_idex, w_int_ack;
    logic [1:0] w_pc_sel;

    assign w_load_use = ex_mem_read &
                        ((id_src1_used & (id_src1 == ex_dst)) |
                         (id_src2_used & (id_src2 == ex_dst)));
    assign w_cnt_zero = (r_cnt == 4'd0);

    always_comb begin
        w_stall_if   = 1'b0;
        w_stall_id   = 1'b0;
        w_bubble_ex  = 1'b0;
        w_stall_mem  = 1'b0;
        w_flush_ifid = 1'b0;
        w_flush_idex = 1'b0;
        w_pc_sel     = 2'd0;
        w_int_ack    = 1'b0;
        w_nxt_state  = r_state;
        w_nxt_cnt    = r_cnt;
        case (r_state)
            c_ST_RUN: begin
                if (mem_wide) begin
                    w_stall_if  = 1'b1;
                    w_stall_id  = 1'b1;
                    w_stall_mem = 1'b1;
                    w_nxt_state = c_ST_MEMWAIT;
                    w_nxt_cnt   = c_MEM_CNT;
                end else if (ex_branch_taken) begin
                    w_flush_ifid = 1'b1;
                    w_flush_idex = 1'b1;
                    w_pc_sel     = 2'd1;
                end else if (w_load_use) begin
                    w_stall_if  = 1'b1;
                    w_stall_id  = 1'b1;
                    w_bubble_ex = 1'b1;
                end else if (r_int_pend | int_req) begin
                    w_stall_if   = 1'b1;
                    w_flush_ifid = 1'b1;
                    w_nxt_state  = c_ST_DRAIN;
                    w_nxt_cnt    = c_DRAIN_CNT;
                end
            end
            c_ST_MEMWAIT: begin
                w_stall_if  = 1'b1;
                w_stall_id  = 1'b1;
                w_stall_mem = 1'b1;
                if (w_cnt_zero) w_nxt_state = c_ST_RUN;
                else            w_nxt_cnt   = r_cnt - 4'd1;
            end
            c_ST_DRAIN: begin
                w_stall_if   = 1'b1;
                w_flush_ifid = 1'b1;
                w_bubble_ex  = 1'b1;
                if (ex_branch_taken) w_pc_sel = 2'd1;
                // A wide access in MEM freezes the drain until it completes.
                if (mem_wide) begin
                    w_stall_mem = 1'b1;
                end else if (w_cnt_zero) begin
                    w_nxt_state = c_ST_PUSH;
                    w_nxt_cnt   = c_PUSH_CNT;
                end else begin
                    w_nxt_cnt = r_cnt - 4'd1;
                end
            end
            c_ST_PUSH: begin
                w_stall_if   = 1'b1;
                w_flush_ifid = 1'b1;
                w_bubble_ex  = 1'b1;
                w_pc_sel     = 2'd2;
                if (w_cnt_zero) begin
                    w_nxt_state = c_ST_VEC;
                    w_nxt_cnt   = c_VEC_CNT;
                end else begin
                    w_nxt_cnt = r_cnt - 4'd1;
                end
            end
            c_ST_VEC: begin
                w_stall_if   = 1'b1;
                w_flush_ifid = 1'b1;
                w_bubble_ex  = 1'b1;
                w_pc_sel     = w_cnt_zero ? 2'd3 : 2'd2;
                if (w_cnt_zero) w_nxt_state = c_ST_ACK;
                else            w_nxt_cnt   = r_cnt - 4'd1;
            end
            c_ST_ACK: begin
                w_int_ack   = 1'b1;
                w_nxt_state = c_ST_RUN;
            end
            default: begin
                w_nxt_state = c_ST_RUN;
                w_nxt_cnt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_ST_RUN;
            r_cnt      <= 4'd0;
            r_int_pend <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            // Leaving VEC consumes the request; a still-high int_req re-arms later.
            if ((r_state == c_ST_VEC) && w_cnt_zero) r_int_pend <= 1'b0;
            else if (int_req)                        r_int_pend <= 1'b1;
        end
    end

    assign stall_if   = rst_n & w_stall_if;
    assign stall_id   = rst_n & w_stall_id;
    assign bubble_ex  = rst_n & w_bubble_ex;
    assign stall_mem  = rst_n & w_stall_mem;
    assign flush_ifid = rst_n & w_flush_ifid;
    assign flush_idex = rst_n & w_flush_idex;
    assign pc_sel     = rst_n ? w_pc_sel : 2'd0;
    assign int_ack    = rst_n & w_int_ack;
    assign state_o    = rst_n ? r_state : 3'd0;

endmodule
`default_nettype wire
